// File: rtl/volume_ctrl_if.sv
// Sample/level-request bundle for the volume stage.
//  sound_i  source -> volume stage   unsigned PCM sample
//  up_i     source -> volume stage   step attenuation index up (quieter)
//  down_i   source -> volume stage   step attenuation index down (louder)
//  sound_o  volume stage -> driver   attenuated sample
// master: the side that drives samples and requests; slave: the volume stage.
interface volume_ctrl_if #(
  parameter int width_p = 24
);
  logic [width_p-1:0] sound_i;
  logic               up_i;
  logic               down_i;
  logic [width_p-1:0] sound_o;

  modport master (
    output sound_i,
    output up_i,
    output down_i,
    input  sound_o
  );

  modport slave (
    input  sound_i,
    input  up_i,
    input  down_i,
    output sound_o
  );
endinterface

// File: rtl/volume_ctrl.sv
// Digital volume stage: attenuates an unsigned PCM sample by a logical right
// shift selected by a 3-bit attenuation index.
//  clk_i    single clock, index updates on rising edge
//  reset_i  asynchronous active-low reset, loads shift_init_p
//  bus      volume_ctrl_if.slave: sound_i, up_i, down_i in; sound_o out
// The index steps once per clock while up_i or down_i is held, saturating at
// shift_min_p / shift_max_p. The output path is purely combinational.
module volume_ctrl #(
  parameter int width_p      = 24,
  parameter int shift_init_p = 3,
  parameter int shift_min_p  = 1,
  parameter int shift_max_p  = 7
) (
  input  logic          clk_i,
  input  logic          reset_i,
  volume_ctrl_if.slave  bus
);

  localparam logic [2:0] ShiftInit = 3'(shift_init_p);
  localparam logic [2:0] ShiftMin  = 3'(shift_min_p);
  localparam logic [2:0] ShiftMax  = 3'(shift_max_p);

  logic [2:0]         shift_q;
  logic [2:0]         shift_d;
  logic [width_p-1:0] sound_s;

  // Saturating one-step update; simultaneous up/down requests cancel.
  function automatic logic [2:0] step_shift(input logic [2:0] cur,
                                            input logic       up,
                                            input logic       dn);
    logic [2:0] nxt;
    nxt = cur;
    case ({up, dn})
      2'b10:   if (cur < ShiftMax) nxt = cur + 3'd1;
      2'b01:   if (cur > ShiftMin) nxt = cur - 3'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_comb begin
    shift_d = step_shift(shift_q, bus.up_i, bus.down_i);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) shift_q <= ShiftInit;
    else          shift_q <= shift_d;
  end

  // Logical shift, zero fill; index never reaches 0 so there is no pass-through.
  assign sound_s     = bus.sound_i >> shift_q;
  assign bus.sound_o = sound_s;

endmodule

// File: tb/tb_volume_ctrl.sv
module tb_volume_ctrl;
  localparam int W = 24;

  logic clk_i;
  logic reset_i;
  volume_ctrl_if #(.width_p(W)) bus ();

  volume_ctrl #(
    .width_p(W), .shift_init_p(3), .shift_min_p(1), .shift_max_p(7)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_cmp;
  int n_bad;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_v;
  int           mshift;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference index: behavioural saturating counter driven by the bench's own stimulus.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) mshift <= 3;
    else if (bus.up_i && !bus.down_i && mshift < 7) mshift <= mshift + 1;
    else if (!bus.up_i && bus.down_i && mshift > 1) mshift <= mshift - 1;
  end

  // Drive one cycle's stimulus just after the falling edge and queue the expected output.
  task automatic drive(input logic up, input logic dn, input logic [W-1:0] s);
    @(negedge clk_i);
    #1;
    bus.up_i    = up;
    bus.down_i  = dn;
    bus.sound_i = s;
    #1;
    sb.push_back(s >> mshift);
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    bus.up_i = 1'b0; bus.down_i = 1'b0; bus.sound_i = 24'h000008;
    #12;
    n_cmp++;
    if (bus.sound_o !== 24'h000001) begin
      n_bad++; $display("FAIL reset_hold got %h want %h", bus.sound_o, 24'h000001);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 24'h000008);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL reset_release got %h want %h", bus.sound_o, exp_v);
    end
    drive(1'b0, 1'b0, 24'h000008);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== 24'h000001 || bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL reset_idle got %h want %h", bus.sound_o, 24'h000001);
    end
  endtask

  task automatic test_up_step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 24'h000040);
      #1; exp_v = sb.pop_front(); n_cmp++;
      if (bus.sound_o !== exp_v) begin
        n_bad++; $display("FAIL up_step%0d got %h want %h", i, bus.sound_o, exp_v);
      end
    end
    drive(1'b0, 1'b0, 24'h000040);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== 24'h000001 || bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL up_shift6 got %h want %h", bus.sound_o, 24'h000001);
    end
  endtask

  task automatic test_cancel();
    drive(1'b1, 1'b1, 24'hFFFFFF);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL cancel_pre got %h want %h", bus.sound_o, exp_v);
    end
    drive(1'b0, 1'b0, 24'hFFFFFF);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== 24'h03FFFF || bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL cancel_post got %h want %h", bus.sound_o, 24'h03FFFF);
    end
  endtask

  task automatic test_down_sat();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 24'h800000);
      #1; exp_v = sb.pop_front(); n_cmp++;
      if (bus.sound_o !== exp_v) begin
        n_bad++; $display("FAIL down_step%0d got %h want %h", i, bus.sound_o, exp_v);
      end
    end
    drive(1'b0, 1'b0, 24'h800000);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== 24'h400000 || bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL down_sat got %h want %h", bus.sound_o, 24'h400000);
    end
  endtask

  task automatic test_up_sat();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 24'hFFFFFF);
      #1; exp_v = sb.pop_front(); n_cmp++;
      if (bus.sound_o !== exp_v) begin
        n_bad++; $display("FAIL up_sat_step%0d got %h want %h", i, bus.sound_o, exp_v);
      end
    end
    drive(1'b0, 1'b0, 24'hFFFFFF);
    #1; exp_v = sb.pop_front(); n_cmp++;
    if (bus.sound_o !== 24'h01FFFF || bus.sound_o !== exp_v) begin
      n_bad++; $display("FAIL up_sat got %h want %h", bus.sound_o, 24'h01FFFF);
    end
  endtask

  task automatic test_async_reset();
    // Still mid-cycle at shift 7: drop reset without any clock edge.
    #1;
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.sound_o !== 24'h1FFFFF) begin
      n_bad++; $display("FAIL async_reset got %h want %h", bus.sound_o, 24'h1FFFFF);
    end
    // Requests held across an edge while in reset must not move the index.
    bus.up_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++;
    if (bus.sound_o !== 24'h1FFFFF) begin
      n_bad++; $display("FAIL reset_hold_up got %h want %h", bus.sound_o, 24'h1FFFFF);
    end
    @(negedge clk_i);
    bus.up_i = 1'b0;
    reset_i  = 1'b1;
  endtask

  task automatic test_ramp();
    logic [W-1:0] s;
    logic u, d;
    s = 24'h000100;
    for (int i = 0; i < 60; i++) begin
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      drive(u, d, s);
      #1; exp_v = sb.pop_front(); n_cmp++;
      if (bus.sound_o !== exp_v) begin
        n_bad++; $display("FAIL ramp%0d got %h want %h (in %h)", i, bus.sound_o, exp_v, s);
      end
      s = s + 24'h013579;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_up_step();
    test_cancel();
    test_down_sat();
    test_up_sat();
    test_async_reset();
    test_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
